// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I sequencer and its ALU.
// Holds FSM states, ALU op codes, opcodes and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECR, S_EXECI, S_AUIPC, S_ALUWB,
        S_JAL, S_JALR, S_JLINK, S_LUI, S_BRANCH
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MDR    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;
    localparam logic [1:0] RES_IMM    = 2'd3;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_REGA  = 2'd2;

    localparam logic [1:0] SRCB_REGB = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    // I-type never subtracts: imm[10] lands on funct7[5] there.
    function automatic logic [3:0] alu_decode(
        input logic [2:0] f3,
        input logic       f7b5,
        input logic       is_r
    );
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000: op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU.
// Ports: ALUA/ALUB operands, ALUControlSignal op -> ALUResult, Zero.
module alu
    import ctrl_pkg::*;
(
    input  logic [31:0] ALUA,
    input  logic [31:0] ALUB,
    input  logic [3:0]  ALUControlSignal,
    output logic [31:0] ALUResult,
    output logic        Zero
);

    logic [4:0] shamt;
    assign shamt = ALUB[4:0];

    always_comb begin
        ALUResult = 32'd0;
        case (ALUControlSignal)
            ALU_ADD:  ALUResult = ALUA + ALUB;
            ALU_SUB:  ALUResult = ALUA - ALUB;
            ALU_AND:  ALUResult = ALUA & ALUB;
            ALU_OR:   ALUResult = ALUA | ALUB;
            ALU_XOR:  ALUResult = ALUA ^ ALUB;
            ALU_SLL:  ALUResult = ALUA << shamt;
            ALU_SRL:  ALUResult = ALUA >> shamt;
            ALU_SRA:  ALUResult = $unsigned($signed(ALUA) >>> shamt);
            ALU_SLT:  ALUResult = {31'd0, $signed(ALUA) < $signed(ALUB)};
            ALU_SLTU: ALUResult = {31'd0, ALUA < ALUB};
            default:  ALUResult = 32'd0;
        endcase
    end

    assign Zero = (ALUResult == 32'd0);

endmodule

// File: rtl/control_alu.sv
// Multicycle RV32I control FSM with its ALU.
// Ports: clk, reset, opcode/funct3/funct7, ALUA/ALUB in; ALU result and all datapath strobes/selects out.
module control_alu
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] ALUA,
    input  logic [31:0] ALUB,
    output logic [31:0] ALUResult,
    output logic        Zero,
    output logic        PCEnable,
    output logic        InstructionRegisterEnable,
    output logic        InstructionOrData,
    output logic [2:0]  ImmediateSrc,
    output logic        REGAEnable,
    output logic        REGBEnable,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUControlSignal,
    output logic [1:0]  ResultSrc,
    output logic        MemWrite,
    output logic        RegWrite
);

    state_t state;

    logic unused_f7;
    assign unused_f7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_RTYPE:  state <= S_EXECR;
                        OP_ITYPE:  state <= S_EXECI;
                        OP_JAL:    state <= S_JAL;
                        OP_BRANCH: state <= S_BRANCH;
                        OP_LUI:    state <= S_LUI;
                        OP_AUIPC:  state <= S_AUIPC;
                        OP_JALR:   state <= S_JALR;
                        default:   state <= S_FETCH;
                    endcase
                end
                S_MEMADR:
                    state <= (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD: state <= S_MEMWB;
                S_EXECR, S_EXECI, S_AUIPC, S_JAL, S_JLINK:
                    state <= S_ALUWB;
                S_JALR:    state <= S_JLINK;
                default:   state <= S_FETCH;
            endcase
        end
    end

    // Kept apart from the strobe logic: Zero depends on this op,
    // and PCEnable in BRANCH depends on Zero.
    always_comb begin
        ALUControlSignal = ALU_ADD;
        case (state)
            S_EXECR:
                ALUControlSignal = alu_decode(funct3, funct7[5], 1'b1);
            S_EXECI:
                ALUControlSignal = alu_decode(funct3, funct7[5], 1'b0);
            S_BRANCH: begin
                case (funct3[2:1])
                    2'b10:   ALUControlSignal = ALU_SLT;
                    2'b11:   ALUControlSignal = ALU_SLTU;
                    default: ALUControlSignal = ALU_SUB;
                endcase
            end
            default: ALUControlSignal = ALU_ADD;
        endcase
        if (reset) ALUControlSignal = ALU_ADD;
    end

    always_comb begin
        PCEnable = 1'b0;
        InstructionRegisterEnable = 1'b0;
        InstructionOrData = 1'b0;
        ImmediateSrc = IMM_I;
        REGAEnable = 1'b0;
        REGBEnable = 1'b0;
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_REGB;
        ResultSrc = RES_ALUOUT;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        case (state)
            S_FETCH: begin
                InstructionRegisterEnable = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ResultSrc = RES_ALU;
                PCEnable = 1'b1;
            end
            S_DECODE: begin
                REGAEnable = 1'b1;
                REGBEnable = 1'b1;
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmediateSrc = (opcode == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
                ImmediateSrc = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: InstructionOrData = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_MDR;
                RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                InstructionOrData = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: ALUSrcA = SRCA_REGA;
            S_EXECI: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
            end
            S_AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmediateSrc = IMM_U;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_JAL: begin
                PCEnable = 1'b1;
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
            end
            S_JALR: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
                ResultSrc = RES_ALU;
                PCEnable = 1'b1;
            end
            S_JLINK: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
            end
            S_LUI: begin
                ImmediateSrc = IMM_U;
                ResultSrc = RES_IMM;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_REGA;
                ImmediateSrc = IMM_B;
                case (funct3)
                    3'b000, 3'b101, 3'b111: PCEnable = Zero;
                    3'b001, 3'b100, 3'b110: PCEnable = !Zero;
                    default:                PCEnable = 1'b0;
                endcase
            end
            default: ;
        endcase
        if (reset) begin
            PCEnable = 1'b0;
            InstructionRegisterEnable = 1'b0;
            InstructionOrData = 1'b0;
            ImmediateSrc = 3'd0;
            REGAEnable = 1'b0;
            REGBEnable = 1'b0;
            ALUSrcA = 2'd0;
            ALUSrcB = 2'd0;
            ResultSrc = 2'd0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    alu u_alu (
        .ALUA             (ALUA),
        .ALUB             (ALUB),
        .ALUControlSignal (ALUControlSignal),
        .ALUResult        (ALUResult),
        .Zero             (Zero)
    );

endmodule

// File: tb/tb_control_alu.sv
// Directed bench for control_alu: per-cycle strobe bundles and ALU results
// are queued as expectations and compared when each cycle settles.
module tb_control_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] ALUA, ALUB;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        PCEnable, InstructionRegisterEnable, InstructionOrData;
    logic [2:0]  ImmediateSrc;
    logic        REGAEnable, REGBEnable;
    logic [1:0]  ALUSrcA, ALUSrcB;
    logic [3:0]  ALUControlSignal;
    logic [1:0]  ResultSrc;
    logic        MemWrite, RegWrite;

    int n_assert = 0;
    int n_fail = 0;

    logic [19:0] exp_q[$];
    logic [32:0] alu_q[$];

    control_alu dut (
        .clk                       (clk),
        .reset                     (reset),
        .opcode                    (opcode),
        .funct3                    (funct3),
        .funct7                    (funct7),
        .ALUA                      (ALUA),
        .ALUB                      (ALUB),
        .ALUResult                 (ALUResult),
        .Zero                      (Zero),
        .PCEnable                  (PCEnable),
        .InstructionRegisterEnable (InstructionRegisterEnable),
        .InstructionOrData         (InstructionOrData),
        .ImmediateSrc              (ImmediateSrc),
        .REGAEnable                (REGAEnable),
        .REGBEnable                (REGBEnable),
        .ALUSrcA                   (ALUSrcA),
        .ALUSrcB                   (ALUSrcB),
        .ALUControlSignal          (ALUControlSignal),
        .ResultSrc                 (ResultSrc),
        .MemWrite                  (MemWrite),
        .RegWrite                  (RegWrite)
    );

    always #5 clk = ~clk;

    logic [19:0] ctl;
    assign ctl = {PCEnable, InstructionRegisterEnable, InstructionOrData,
                  ImmediateSrc, REGAEnable, REGBEnable, ALUSrcA, ALUSrcB,
                  ALUControlSignal, ResultSrc, MemWrite, RegWrite};

    function automatic logic [19:0] e(
        input logic pc, input logic ir, input logic iord,
        input logic [2:0] imm, input logic ra, input logic rb,
        input logic [1:0] sa, input logic [1:0] sb,
        input logic [3:0] op, input logic [1:0] res,
        input logic mw, input logic rw
    );
        return {pc, ir, iord, imm, ra, rb, sa, sb, op, res, mw, rw};
    endfunction

    // One clock cycle: queue expectations, compare at the falling edge.
    task automatic cyc(input string tag, input logic [19:0] ex,
                       input logic chk_alu = 1'b0,
                       input logic [31:0] er = 32'd0,
                       input logic ez = 1'b0);
        logic [19:0] want;
        logic [32:0] want_alu;
        exp_q.push_back(ex);
        if (chk_alu) alu_q.push_back({er, ez});
        @(negedge clk);
        want = exp_q.pop_front();
        n_assert++;
        assert (ctl === want) else begin
            n_fail++;
            $error("FAIL %s ctl: got %h expected %h", tag, ctl, want);
        end
        if (chk_alu) begin
            want_alu = alu_q.pop_front();
            n_assert++;
            assert ({ALUResult, Zero} === want_alu) else begin
                n_fail++;
                $error("FAIL %s alu: got %h/%b expected %h/%b", tag,
                       ALUResult, Zero, want_alu[32:1], want_alu[0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [19:0] E_FETCH, E_DEC, E_ALUWB, E_ZERO;

    task automatic run_r(input string tag, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez);
        opcode = 7'b0110011; funct3 = f3; funct7 = f7;
        cyc({tag, "_fetch"}, E_FETCH);
        cyc({tag, "_decode"}, E_DEC);
        ALUA = a; ALUB = b;
        cyc({tag, "_execr"}, e(0,0,0,0,0,0,2,0,op,0,0,0), 1'b1, er, ez);
        cyc({tag, "_aluwb"}, E_ALUWB);
    endtask

    initial begin
        E_FETCH = e(1,1,0,0,0,0,0,2,0,2,0,0);
        E_DEC   = e(0,0,0,2,1,1,1,1,0,0,0,0);
        E_ALUWB = e(0,0,0,0,0,0,0,0,0,0,0,1);
        E_ZERO  = 20'd0;

        reset = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        ALUA = 32'd5; ALUB = 32'd5;
        @(posedge clk); #1;
        cyc("reset_hold", E_ZERO);
        reset = 1'b0;

        // lw: five cycles back to FETCH
        opcode = 7'b0000011;
        cyc("lw_fetch", E_FETCH);
        cyc("lw_decode", E_DEC);
        cyc("lw_memadr", e(0,0,0,0,0,0,2,1,0,0,0,0));
        cyc("lw_memread", e(0,0,1,0,0,0,0,0,0,0,0,0));
        cyc("lw_memwb", e(0,0,0,0,0,0,0,0,0,1,0,1));

        // sw: four cycles, one MemWrite strobe
        opcode = 7'b0100011;
        cyc("sw_fetch", E_FETCH);
        cyc("sw_decode", E_DEC);
        cyc("sw_memadr", e(0,0,0,1,0,0,2,1,0,0,0,0));
        cyc("sw_memwrite", e(0,0,1,0,0,0,0,0,0,0,1,0));

        // R-type ALU cases
        run_r("sub", 3'b000, 7'h20, 4'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0);
        run_r("sra", 3'b101, 7'h20, 4'd7, 32'h80000000, 32'd4,
              32'hF8000000, 1'b0);
        run_r("sltu", 3'b011, 7'h00, 4'd9, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        run_r("slt", 3'b010, 7'h00, 4'd8, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
        run_r("zero", 3'b000, 7'h20, 4'd1, 32'd3, 32'd3, 32'd0, 1'b1);

        // addi with imm[10] set stays ADD
        opcode = 7'b0010011; funct3 = 3'b000; funct7 = 7'h20;
        ALUA = 32'd10; ALUB = 32'h400;
        cyc("addi_fetch", E_FETCH);
        cyc("addi_decode", E_DEC);
        cyc("addi_execi", e(0,0,0,0,0,0,2,1,0,0,0,0), 1'b1, 32'h40A, 1'b0);
        cyc("addi_aluwb", E_ALUWB);

        // beq taken / bne not taken on equal operands
        opcode = 7'b1100011; funct3 = 3'b000; funct7 = 7'h00;
        ALUA = 32'd9; ALUB = 32'd9;
        cyc("beq_fetch", E_FETCH);
        cyc("beq_decode", E_DEC);
        cyc("beq_branch", e(1,0,0,2,0,0,2,0,1,0,0,0), 1'b1, 32'd0, 1'b1);
        funct3 = 3'b001;
        cyc("bne_fetch", E_FETCH);
        cyc("bne_decode", E_DEC);
        cyc("bne_branch", e(0,0,0,2,0,0,2,0,1,0,0,0), 1'b1, 32'd0, 1'b1);

        // unknown opcode is a NOP
        opcode = 7'h7F; funct3 = 3'b000;
        cyc("nop_fetch", E_FETCH);
        cyc("nop_decode", E_DEC);

        // reset during MEMWRITE
        opcode = 7'b0100011;
        cyc("rst_fetch", E_FETCH);
        cyc("rst_decode", E_DEC);
        cyc("rst_memadr", e(0,0,0,1,0,0,2,1,0,0,0,0));
        reset = 1'b1;
        cyc("rst_memwrite", E_ZERO);
        reset = 1'b0;
        cyc("rst_after", E_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
